freq_meas_ctrl: RTL
===================

# freq_meas_ctrl

Measurement sequencer for the frequency meter. It drives the gate (`counter_en`) and `clear` inputs of the 8-digit BCD event counter from the 50 MHz system clock, and repeats a fixed cycle: clear, open gate, close gate, settle, latch. After each cycle it captures the counter's eight BCD digits and overflow flag into stable display registers for the seven-segment/readout logic.

## Interface
Parameters:
- `GATE_CYCLES`, 50_000_000: gate-open length in clk_50M cycles (1 s gives a direct reading in Hz). Legal range ≥1.
- `CLEAR_CYCLES`, 1_000_000: clear-asserted length in cycles. Legal range ≥1.
- `SETTLE_CYCLES`, 1000: wait after the gate closes before latching. Legal range ≥1.

Ports (one clock; reset is asynchronous and active-low):
- `clk_50M` input 1: system clock, all logic on the rising edge.
- `rst_n` input 1: asynchronous active-low reset.
- `run` input 1: level. High = measure continuously; low = finish the current cycle, then idle.
- `cnt_result` input 32: counter digits, `{result8,…,result1}`; result1 is the units digit in [3:0].
- `cnt_over` input 1: counter overflow flag.
- `counter_en` output 1: gate to the counter.
- `clear` output 1: clear to the counter.
- `disp_bcd` output 32: latched digits, same packing as `cnt_result`.
- `disp_over` output 1: latched overflow.
- `meas_done` output 1: one-cycle pulse when `disp_*` is updated.
- `busy` output 1: high in any state except IDLE.

## Operation
- States: IDLE, CLEAR, GATE, SETTLE, LATCH. Encoding is free. All outputs are registered.
- IDLE: `clear`=1, `counter_en`=0. If `run`=1 is sampled, go to CLEAR.
- CLEAR: `clear`=1 for exactly CLEAR_CYCLES cycles, then go to GATE.
- GATE: `clear`=0, `counter_en`=1 for exactly GATE_CYCLES cycles, then go to SETTLE.
- SETTLE: both outputs 0 for SETTLE_CYCLES cycles, then go to LATCH.
- LATCH: lasts 1 cycle. On its closing edge, `disp_bcd`<=`cnt_result`, `disp_over`<=`cnt_over`, `meas_done`<=1. Next state is CLEAR if `run`=1, otherwise IDLE.
- Inputs `cnt_result` and `cnt_over` belong to the ext_signal domain. They are sampled only in LATCH, when the counter is frozen, so no synchronizer is used on them.
- One shared down-counter is used for phase timing. Its width is `$clog2(max(GATE_CYCLES,CLEAR_CYCLES,SETTLE_CYCLES)+1)`. It reloads on every state entry. There must be no off-by-one: phase lengths are exact.
- `run` is sampled only in IDLE and LATCH. Toggling `run` mid-cycle never aborts or shortens a phase.
- `disp_*` hold their values between LATCH events and in IDLE.
- Limitation: the counter clears only on ext_signal edges. With no input signal, the latched value is whatever the counter holds; this block does not detect a missing signal.

## Timing
- Reset values: state=IDLE, `clear`=1, `counter_en`=0, `disp_bcd`=0, `disp_over`=0, `meas_done`=0, `busy`=0, timer=0.
- Reset asserted mid-cycle returns to the reset values immediately. The gate drops asynchronously and `disp_*` is zeroed.
- Counting edges from the one where `run` is sampled in IDLE:
  - `busy` and CLEAR start 1 cycle later.
  - `counter_en` rises CLEAR_CYCLES cycles after that.
  - `meas_done` is high in the cycle after LATCH, together with the new `disp_*`.
- Total latency from sampling `run` to the `meas_done` cycle: 1+CLEAR_CYCLES+GATE_CYCLES+SETTLE_CYCLES+1 cycles.
- Continuous period: 1+CLEAR_CYCLES+GATE_CYCLES+SETTLE_CYCLES cycles between `meas_done` pulses.
- `busy` falls in the cycle after LATCH when returning to IDLE.
- `clear` and `counter_en` are never high in the same cycle.

## Test plan
All scenarios use GATE_CYCLES=100, CLEAR_CYCLES=4, SETTLE_CYCLES=3.
- Reset check: drive `rst_n`=0 → `clear`=1, `counter_en`=0, `disp_bcd`=0, `busy`=0. Release reset with `run`=0 → state stays IDLE indefinitely.
- Single shot: pulse `run` high for 1 cycle, with a stub driving `cnt_result`=32'h87654321 and `cnt_over`=0 → `clear` high for 4 cycles, `counter_en` high for exactly 100 cycles, then `meas_done` at cycle 109 with `disp_bcd`=32'h87654321. Then IDLE, `clear`=1.
- Continuous: hold `run`=1 and change the stub value after each pulse → `meas_done` every 108 cycles, each time carrying the value present in that LATCH cycle.
- Live count: connect the real counter with ext_signal period 70 ns, over 3 cycles → `disp_bcd` = BCD count of ~28 negedges (±1 for gate alignment), `disp_over`=0. Using a stub with `cnt_over`=1 → `disp_over`=1.
- Run drop: deassert `run` during GATE → the phase still completes all 100 cycles, `meas_done` fires once, then IDLE.
- Mid-cycle reset: assert `rst_n`=0 at gate cycle 50 → `counter_en` drops with no clock edge, all outputs at reset values. After release with `run`=1 → a full new cycle starting with CLEAR.

Source files
------------

// File: rtl/freq_meas_ctrl.sv
// Frequency-meter sequencer: clear -> gate -> settle -> latch, repeated while run is high.
// Latency: meas_done 1+CLEAR+GATE+SETTLE+1 cycles after run is sampled; period 1+CLEAR+GATE+SETTLE.
// No backpressure: phases always run to completion; run only decides whether another cycle follows.
module freq_meas_ctrl #(
    parameter int GATE_CYCLES   = 50_000_000,
    parameter int CLEAR_CYCLES  = 1_000_000,
    parameter int SETTLE_CYCLES = 1000
) (
    input  logic        clk_50M,
    input  logic        rst_n,
    input  logic        run,
    input  logic [31:0] cnt_result,
    input  logic        cnt_over,
    output logic        counter_en,
    output logic        clear,
    output logic [31:0] disp_bcd,
    output logic        disp_over,
    output logic        meas_done,
    output logic        busy
);

    localparam int MAX_GC  = (GATE_CYCLES > CLEAR_CYCLES) ? GATE_CYCLES : CLEAR_CYCLES;
    localparam int MAX_CYC = (MAX_GC > SETTLE_CYCLES) ? MAX_GC : SETTLE_CYCLES;
    localparam int TW      = $clog2(MAX_CYC + 1);

    localparam logic [TW-1:0] CLEAR_LD  = TW'(CLEAR_CYCLES - 1);
    localparam logic [TW-1:0] GATE_LD   = TW'(GATE_CYCLES - 1);
    localparam logic [TW-1:0] SETTLE_LD = TW'(SETTLE_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_GATE,
        S_SETTLE,
        S_LATCH
    } state_t;

    state_t        state;
    logic [TW-1:0] timer;
    logic          run_q;

    // Timer is loaded with length-1 on entry, so a phase ends on the edge where it reads zero.
    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            timer      <= '0;
            run_q      <= 1'b0;
            clear      <= 1'b1;
            counter_en <= 1'b0;
            disp_bcd   <= '0;
            disp_over  <= 1'b0;
            meas_done  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            run_q     <= run;
            meas_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (run_q) begin
                        state <= S_CLEAR;
                        timer <= CLEAR_LD;
                        clear <= 1'b1;
                        busy  <= 1'b1;
                    end
                end
                S_CLEAR: begin
                    if (timer == '0) begin
                        state      <= S_GATE;
                        timer      <= GATE_LD;
                        clear      <= 1'b0;
                        counter_en <= 1'b1;
                    end else begin
                        timer <= timer - TW'(1);
                    end
                end
                S_GATE: begin
                    if (timer == '0) begin
                        state      <= S_SETTLE;
                        timer      <= SETTLE_LD;
                        counter_en <= 1'b0;
                    end else begin
                        timer <= timer - TW'(1);
                    end
                end
                S_SETTLE: begin
                    if (timer == '0) begin
                        state <= S_LATCH;
                    end else begin
                        timer <= timer - TW'(1);
                    end
                end
                S_LATCH: begin
                    // Counter is frozen here, so the unsynchronised digits are stable.
                    disp_bcd  <= cnt_result;
                    disp_over <= cnt_over;
                    meas_done <= 1'b1;
                    clear     <= 1'b1;
                    if (run_q) begin
                        state <= S_CLEAR;
                        timer <= CLEAR_LD;
                    end else begin
                        state <= S_IDLE;
                        timer <= '0;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state      <= S_IDLE;
                    timer      <= '0;
                    clear      <= 1'b1;
                    counter_en <= 1'b0;
                    busy       <= 1'b0;
                end
            endcase
        end
    end

endmodule
